// File: rtl/dcache_refill_unit.sv
// Data-cache miss handler: optional dirty-victim writeback, then an in-order
// word-by-word line fetch into the cache array, finishing with a tagged done pulse.
module dcache_refill_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned ID_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [ID_W-1:0]   miss_ldstID,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              miss_ready,
  output logic [IDX_W-1:0]  victim_rd_idx,
  input  logic [DATA_W-1:0] victim_rd_data,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_line_addr,
  output logic              fill_done,
  output logic [ID_W-1:0]   fill_ldstID,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] miss_line, victim_line;
  logic [ID_W-1:0]   ldst_id;
  logic [ADDR_W-1:0] word_off;

  assign word_off = ADDR_W'(cnt) << 2;

  // State, counter and the latched miss descriptor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      miss_line   <= '0;
      victim_line <= '0;
      ldst_id     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && miss_valid) begin
        miss_line   <= {miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        victim_line <= {victim_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        ldst_id     <= miss_ldstID;
      end
    end
  end

  // Next state and outputs; every output is a pure function of state/regs/inputs
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    miss_ready     = 1'b0;
    busy           = 1'b1;
    victim_rd_idx  = '0;
    fill_we        = 1'b0;
    fill_idx       = '0;
    fill_data      = '0;
    fill_line_addr = '0;
    fill_done      = 1'b0;
    fill_ldstID    = '0;
    mem_req        = 1'b0;
    mem_rw         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    unique case (state)
      IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
        if (miss_valid) begin
          cnt_nxt   = '0;
          state_nxt = victim_dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        mem_req       = 1'b1;
        mem_rw        = 1'b1;
        mem_addr      = victim_line + word_off;
        victim_rd_idx = cnt;
        mem_wdata     = victim_rd_data;
        if (mem_ack) begin
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = RD_REQ;
          end else begin
            cnt_nxt = IDX_W'(cnt + 1'b1);
          end
        end
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = miss_line + word_off;
        if (mem_ack) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          fill_we        = 1'b1;
          fill_idx       = cnt;
          fill_data      = mem_rdata;
          fill_line_addr = miss_line;
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = IDX_W'(cnt + 1'b1);
            state_nxt = RD_REQ;
          end
        end
      end
      DONE: begin
        fill_done   = 1'b1;
        fill_ldstID = ldst_id;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for dcache_refill_unit: a memory/victim responder, a queue of
// expected memory ops, fills and completions, and a negedge monitor that pops them.
module tb_dcache_refill_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic [3:0]  miss_ldstID;
  logic        victim_dirty;
  logic [31:0] victim_addr;
  logic        miss_ready;
  logic [1:0]  victim_rd_idx;
  logic [31:0] victim_rd_data;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic [31:0] fill_line_addr;
  logic        fill_done;
  logic [3:0]  fill_ldstID;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  dcache_refill_unit dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ldstID(miss_ldstID),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .miss_ready(miss_ready),
    .victim_rd_idx(victim_rd_idx), .victim_rd_data(victim_rd_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_line_addr(fill_line_addr), .fill_done(fill_done), .fill_ldstID(fill_ldstID),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; } mem_op_t;
  typedef struct { logic [1:0] idx; logic [31:0] data; logic [31:0] line; } fill_t;
  typedef struct { logic [3:0] id; int lat; int acc; } done_t;

  mem_op_t mem_q[$];
  fill_t   fill_q[$];
  done_t   done_q[$];
  mem_op_t op;
  fill_t   fe;
  done_t   de;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Responder / bench control
  logic [31:0] vbase = 32'h0;
  logic [31:0] rd_base = 32'h0;
  logic        rand_ack = 1'b0;
  logic        stray = 1'b0;
  int          rv_dly = 0;
  int          stall_left = 0;
  logic        pending = 1'b0;
  int          dly = 0;
  logic [31:0] rd_addr = 32'h0;

  // Monitor-produced observations
  logic        acc_seen = 1'b0;
  int          acc_edge = 0;
  int          last_done_edge = 0;
  int          wr_hs = 0;
  int          fills_seen = 0;
  logic        rd_hs = 1'b0;
  logic [31:0] rd_hs_addr = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] st_addr, st_wdata;
  logic [1:0]  st_idx;
  logic        st_rw;

  assign victim_rd_data = vbase + 32'(victim_rd_idx);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no matching expectation (cycle %0d)", name, cyc);
  endtask

  // Monitor: sample away from the active edge and pop expectations on each DUT event
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("ready_vs_busy", 64'(miss_ready), 64'(!busy));
      if (miss_valid && miss_ready) begin
        acc_seen = 1'b1;
        acc_edge = cyc + 1;
      end
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) unexpected("mem_req");
        else begin
          op = mem_q.pop_front();
          chk("mem_rw", 64'(mem_rw), 64'(op.rw));
          chk("mem_addr", 64'(mem_addr), 64'(op.addr));
          if (op.rw) begin
            chk("mem_wdata", 64'(mem_wdata), 64'(op.wdata));
            chk("victim_rd_idx", 64'(victim_rd_idx), 64'(op.addr[3:2]));
            wr_hs++;
          end else begin
            rd_hs = 1'b1;
            rd_hs_addr = mem_addr;
          end
        end
      end
      if (prev_stall && mem_req) begin
        chk("stall_addr", 64'(mem_addr), 64'(st_addr));
        chk("stall_rw", 64'(mem_rw), 64'(st_rw));
        if (st_rw) begin
          chk("stall_wdata", 64'(mem_wdata), 64'(st_wdata));
          chk("stall_idx", 64'(victim_rd_idx), 64'(st_idx));
        end
      end
      prev_stall = mem_req && !mem_ack;
      st_addr = mem_addr; st_wdata = mem_wdata; st_idx = victim_rd_idx; st_rw = mem_rw;
      if (fill_we) begin
        fills_seen++;
        if (fill_q.size() == 0) unexpected("fill_we");
        else begin
          fe = fill_q.pop_front();
          chk("fill_idx", 64'(fill_idx), 64'(fe.idx));
          chk("fill_data", 64'(fill_data), 64'(fe.data));
          chk("fill_line_addr", 64'(fill_line_addr), 64'(fe.line));
        end
      end
      if (fill_done) begin
        last_done_edge = cyc + 1;
        if (done_q.size() == 0) unexpected("fill_done");
        else begin
          de = done_q.pop_front();
          chk("fill_ldstID", 64'(fill_ldstID), 64'(de.id));
          if (de.lat >= 0) chk("done_latency", 64'(cyc + 1 - de.acc), 64'(de.lat));
        end
      end
    end
  end

  // Memory responder: one read outstanding, configurable ack/rvalid timing and stray pulses
  initial begin
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pending = 1'b0; rd_hs = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0;
      end else begin
        if (rd_hs) begin
          rd_hs = 1'b0;
          pending = 1'b1;
          rd_addr = rd_hs_addr;
          dly = (rv_dly < 0) ? int'($urandom_range(0, 2)) : rv_dly;
        end
        if (mem_req) begin
          if (mem_rw && wr_hs == 1 && stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
          end else mem_ack = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        if (pending && dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_base + 32'(rd_addr[3:2]);
          pending = 1'b0;
        end else begin
          if (pending) dly--;
          mem_rvalid = (!pending && stray) ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Present a miss, wait (bounded) for acceptance, then push the expected transaction trace
  task automatic issue_miss(input logic [31:0] a, input logic [3:0] id, input logic d,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] rb, input int lat);
    int n = 0;
    logic [31:0] mline = a & ~32'hF;
    logic [31:0] vline = va & ~32'hF;
    miss_addr = a; miss_ldstID = id; victim_dirty = d; victim_addr = va; vbase = vb;
    miss_valid = 1'b1;
    acc_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!acc_seen && n < 300);
    miss_valid = 1'b0;
    if (!acc_seen) unexpected("accept_timeout");
    else begin
      wr_hs = 0;
      rd_base = rb;
      if (d) for (int i = 0; i < 4; i++) mem_q.push_back('{1'b1, vline + 32'(4 * i), vb + 32'(i)});
      for (int i = 0; i < 4; i++) begin
        mem_q.push_back('{1'b0, mline + 32'(4 * i), 32'h0});
        fill_q.push_back('{2'(i), rb + 32'(i), mline});
      end
      done_q.push_back('{id, lat, acc_edge});
    end
    acc_seen = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy || done_q.size() != 0) && n < 500);
    if (n >= 500) unexpected("idle_timeout");
  endtask

  int f0;
  int n;
  int acc_b;

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = 32'h0; miss_ldstID = 4'h0;
    victim_dirty = 1'b0; victim_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", 64'(|{busy, mem_req, mem_rw, mem_addr, mem_wdata, fill_we, fill_idx,
        fill_data, fill_line_addr, fill_done, fill_ldstID, victim_rd_idx}), 64'(0));
    chk("reset_miss_ready", 64'(miss_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss, minimum latency
    issue_miss(32'h48, 4'd5, 1'b0, 32'h0, 32'h0, 32'h100, 9);
    wait_idle();

    // Dirty miss, ack tied high
    issue_miss(32'h10, 4'd3, 1'b1, 32'h80, 32'hA0, 32'h200, 13);
    wait_idle();
    chk("dirty_write_count", 64'(wr_hs), 64'(4));

    // Writeback backpressure on word 1
    stall_left = 3;
    issue_miss(32'h330, 4'd2, 1'b1, 32'h1F4, 32'hBEEF0000, 32'h300, 16);
    wait_idle();
    chk("bp_write_count", 64'(wr_hs), 64'(4));

    // Second miss held while the first is in RD_WAIT
    issue_miss(32'h204, 4'd5, 1'b0, 32'h0, 32'h0, 32'h400, 9);
    @(posedge clk); #1;
    miss_addr = 32'h6A8; miss_ldstID = 4'd7; victim_dirty = 1'b0; miss_valid = 1'b1;
    chk("busy_miss_ready", 64'(miss_ready), 64'(0));
    issue_miss(32'h6A8, 4'd7, 1'b0, 32'h0, 32'h0, 32'h600, 9);
    acc_b = done_q.size() > 0 ? done_q[done_q.size() - 1].acc : -1;
    chk("accept_after_done", 64'(acc_b), 64'(last_done_edge + 1));
    wait_idle();

    // Reset while waiting for the third word
    rv_dly = 2;
    f0 = fills_seen;
    issue_miss(32'h5C0, 4'd9, 1'b0, 32'h0, 32'h0, 32'h500, -1);
    n = 0;
    while (fills_seen < f0 + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) unexpected("fill_timeout");
    @(posedge clk); #1;
    chk("pre_reset_rd_wait", 64'({busy, mem_req, fill_we}), 64'(3'b100));
    #1 rst = 1'b1;
    #1;
    chk("midreset_outputs_zero", 64'(|{busy, mem_req, mem_rw, mem_addr, mem_wdata, fill_we, fill_idx,
        fill_data, fill_line_addr, fill_done, fill_ldstID, victim_rd_idx}), 64'(0));
    chk("midreset_miss_ready", 64'(miss_ready), 64'(1));
    mem_q.delete(); fill_q.delete(); done_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    rv_dly = 0;

    // Stray ack/rvalid while idle
    stray = 1'b1;
    repeat (8) begin
      @(posedge clk); #2;
      chk("stray_busy", 64'(busy), 64'(0));
      chk("stray_fill_we", 64'(fill_we), 64'(0));
    end

    // Randomized traffic
    rand_ack = 1'b1;
    rv_dly = -1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue_miss($urandom, 4'($urandom), 1'($urandom), $urandom, $urandom, $urandom, -1);
      wait_idle();
    end
    stray = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", 64'(mem_q.size() + fill_q.size() + done_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
